pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//   Fetch sequencer that owns the program counter and drives the instruction-memory port.
//   Issues one outstanding fetch at a time over a req/gnt/rvalid handshake.
//   Presents the returned instruction, with its PC, to decode under a stall input.
//   Applies branch/jump redirects from execute and drops any in-flight fetch they invalidate.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset
//   EXC_VECTOR  32'h0000_0080  exception target; used only when PC_FETCH_EXC_EN is defined
// PORTS
//   clk          in   1   clock; all state updates on posedge
//   reset        in   1   asynchronous, active-low reset
//   stall        in   1   decode cannot accept; holds inst_valid/inst/inst_pc
//   redirect     in   1   branch/jump taken this cycle
//   redirect_pc  in   32  redirect target; bits [1:0] ignored (forced 2'b00)
//   imem_req     out  1   fetch request
//   imem_addr    out  32  fetch address (= PC register)
//   imem_gnt     in   1   request accepted this cycle
//   imem_rvalid  in   1   read data valid; earliest cycle after gnt
//   imem_rdata   in   32  instruction word
//   inst_valid   out  1   instruction available to decode
//   inst         out  32  instruction word (registered)
//   inst_pc      out  32  address of inst
//   exc          in   1   exception request (PC_FETCH_EXC_EN only)
//   epc          out  32  saved PC (PC_FETCH_EXC_EN only)
// BEHAVIOUR
//   - Reset low, any time: state=BOOT, pc=RESET_PC, kill=0, imem_req=0, inst_valid=0,
//     inst=0, inst_pc=0, epc=0. Any outstanding fetch is abandoned; its late rvalid is ignored.
//   - States:
//     - BOOT: 1 idle cycle after reset release, then REQ.
//     - REQ: imem_req=1, imem_addr=pc.
//       - gnt -> WAIT.
//       - redirect without gnt: pc<=redirect_pc, stay in REQ.
//       - redirect with gnt: pc<=redirect_pc, kill<=1, go to WAIT.
//     - WAIT: imem_req=0.
//       - rvalid & !kill & !redirect: inst<=rdata, inst_pc<=pc, go to OUT.
//       - rvalid & kill: drop the data, kill<=0, go to REQ.
//       - redirect without rvalid: pc<=redirect_pc, kill<=1, stay in WAIT.
//       - redirect with rvalid: drop the data, pc<=redirect_pc, kill<=0, go to REQ.
//     - OUT: inst_valid=1.
//       - !stall (consumed): pc<=pc+4, go to REQ.
//       - stall: all outputs held stable.
//       - redirect (overrides stall): inst_valid<=0, pc<=redirect_pc, go to REQ.
//   - Latency: gnt in cycle N, rvalid in N+1 -> inst_valid in N+2 -> next imem_req in N+3.
//     Peak throughput is 1 instruction per 3 cycles.
//   - Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
//     pc[1:0] is always 2'b00.
//   - rvalid seen in BOOT, REQ or OUT is a protocol error and is ignored.
//   - kill is set only while a response is owed; at most one response is outstanding.
// CONFIGURATION
//   - PC_FETCH_EXC_EN defined:
//     - exc and epc ports exist.
//     - exc in any non-BOOT state: pc<=EXC_VECTOR, epc<=inst_pc if in OUT else pc.
//     - Outstanding-fetch and inst_valid handling is identical to redirect.
//     - exc has priority over redirect in the same cycle.
//   - PC_FETCH_EXC_EN undefined: exc and epc ports are absent; EXC_VECTOR is unused.
// TESTING
//   - Reset release, gnt same cycle, rvalid next, rdata=32'h2008_0005, stall=0
//     -> imem_addr=0; inst_valid with inst=32'h2008_0005, inst_pc=0; next imem_addr=4.
//   - stall=1 for 5 cycles in OUT -> inst/inst_pc stable, no imem_req.
//     stall drops -> imem_addr=pc+4 in the next cycle.
//   - redirect=1, redirect_pc=32'h0000_0103 while in WAIT; rvalid 2 cycles later
//     -> response dropped, no inst_valid, next imem_addr=32'h0000_0100.
//   - redirect in the same cycle as gnt -> that response is dropped;
//     the following fetch targets redirect_pc.
//   - pc=32'hFFFF_FFFC fetched and consumed -> next imem_addr=32'h0000_0000.
//   - reset asserted in WAIT, rvalid arrives during reset
//     -> outputs zero, no inst_valid; first request after BOOT uses RESET_PC.
//   - (PC_FETCH_EXC_EN) exc and redirect together in OUT with inst_pc=32'h40
//     -> imem_addr=EXC_VECTOR, epc=32'h40.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues single-outstanding imem fetches, presents inst to decode.
// Optional exception redirect/EPC capture enabled by defining PC_FETCH_EXC_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
`ifdef PC_FETCH_EXC_EN
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
`endif
  localparam int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
`ifdef PC_FETCH_EXC_EN
  ,
  input  logic            exc,
  output logic [XLEN-1:0] epc
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            kill_q, kill_d;
  logic            req_q, valid_q;
  logic            flush_c;
  logic [XLEN-1:0] flush_pc_c;
`ifdef PC_FETCH_EXC_EN
  logic [XLEN-1:0] epc_q, epc_d;
`endif

  // Target alignment drops the two low redirect bits entirely.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Control-flow change request; exception outranks branch redirect.
  always_comb begin
`ifdef PC_FETCH_EXC_EN
    flush_c    = (exc | redirect) & (state_q != ST_BOOT);
    flush_pc_c = exc ? {EXC_VECTOR[XLEN-1:2], 2'b00} : {redirect_pc[XLEN-1:2], 2'b00};
`else
    flush_c    = redirect & (state_q != ST_BOOT);
    flush_pc_c = {redirect_pc[XLEN-1:2], 2'b00};
`endif
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
`ifdef PC_FETCH_EXC_EN
    epc_d     = epc_q;
    if (exc && (state_q != ST_BOOT)) begin
      epc_d = (state_q == ST_OUT) ? inst_pc_q : pc_q;
    end
`endif
    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          state_d = ST_WAIT;
        end
        if (flush_c) begin
          pc_d   = flush_pc_c;
          kill_d = imem_gnt;
        end
      end
      ST_WAIT: begin
        if (flush_c) begin
          pc_d = flush_pc_c;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            state_d   = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (flush_c) begin
          pc_d    = flush_pc_c;
          state_d = ST_REQ;
        end else if (!stall) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State register; req/valid are registered decodes of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= {RESET_PC[XLEN-1:2], 2'b00};
      kill_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
`ifdef PC_FETCH_EXC_EN
      epc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      req_q     <= (state_d == ST_REQ);
      valid_q   <= (state_d == ST_OUT);
`ifdef PC_FETCH_EXC_EN
      epc_q     <= epc_d;
`endif
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
`ifdef PC_FETCH_EXC_EN
  assign epc        = epc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed spec scenarios plus random traffic vs a transaction-level model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect, imem_gnt, imem_rvalid, exc;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;
`ifdef PC_FETCH_EXC_EN
  logic [31:0] epc;
`endif

  int checks = 0;
  int failures = 0;
  int delivered = 0;

  // Model: architectural PC, outstanding-response bookkeeping, decode slot contents.
  logic        m_boot, m_owed, m_doomed, m_have;
  logic [31:0] m_pc, m_fpc, m_inst, m_inst_pc, m_epc;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
`ifdef PC_FETCH_EXC_EN
    ,
    .exc        (exc),
    .epc        (epc)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_owed = 1'b0; m_doomed = 1'b0; m_have = 1'b0;
    m_pc = RESET_PC; m_fpc = 32'h0; m_inst = 32'h0; m_inst_pc = 32'h0; m_epc = 32'h0;
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(!m_boot && !m_owed && !m_have));
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_have));
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_inst_pc);
`ifdef PC_FETCH_EXC_EN
    chk("epc", epc, m_epc);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then check at the following negedge.
  task automatic cycle(input logic s, input logic r, input logic [31:0] rpc,
                       input logic g, input logic v, input logic e);
    logic        fl;
    logic [31:0] tgt;
    stall = s; redirect = r; redirect_pc = rpc; imem_gnt = g; imem_rvalid = v; exc = e;
    imem_rdata = (v && m_owed) ? mem(m_fpc) : $urandom;
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      fl  = r | e;
      tgt = e ? EXC_VEC : {rpc[31:2], 2'b00};
      if (e) m_epc = m_have ? m_inst_pc : m_pc;
      if (m_have) begin
        if (fl) begin
          m_have = 1'b0; m_pc = tgt;
        end else if (!s) begin
          m_have = 1'b0; m_pc = m_pc + 32'd4;
        end
      end else if (m_owed) begin
        if (fl) begin
          m_pc = tgt; m_doomed = 1'b1;
        end
        if (v) begin
          m_owed = 1'b0;
          if (!m_doomed) begin
            m_have = 1'b1; m_inst = mem(m_fpc); m_inst_pc = m_fpc; delivered++;
          end
          m_doomed = 1'b0;
        end
      end else begin
        if (g) begin
          m_owed = 1'b1; m_doomed = fl; m_fpc = m_pc;
        end
        if (fl) m_pc = tgt;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic        s, r, g, v;
    logic [31:0] rpc;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; exc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b1;

    // Boot idle cycle, then first fetch at RESET_PC.
    cycle(0, 0, 0, 0, 0, 0);
    chk("first_addr", imem_addr, 32'h0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("t1_inst", inst, 32'h2008_0005);
    chk("t1_inst_pc", inst_pc, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t1_next_addr", imem_addr, 32'h4);

    // Stall holds the decode slot for five cycles.
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      chk("t2_hold_pc", inst_pc, 32'h4);
      chk("t2_no_req", 32'(imem_req), 32'h0);
    end
    cycle(0, 0, 0, 0, 0, 0);
    chk("t2_next_addr", imem_addr, 32'h8);

    // Redirect while waiting; late response dropped.
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h0000_0103, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("t3_valid", 32'(inst_valid), 32'h0);
    chk("t3_addr", imem_addr, 32'h100);

    // Redirect coinciding with grant.
    cycle(0, 1, 32'h0000_0200, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("t4_valid", 32'(inst_valid), 32'h0);
    chk("t4_addr", imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("t5_inst_pc", inst_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t5_wrap_addr", imem_addr, 32'h0);

    // Reset in WAIT with a response arriving during reset.
    cycle(0, 0, 0, 1, 0, 0);
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    imem_rvalid = 1'b0;
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
    chk("t6_req", 32'(imem_req), 32'h1);
    chk("t6_addr", imem_addr, RESET_PC);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);

`ifdef PC_FETCH_EXC_EN
    // Exception beats redirect in OUT; EPC captures the presented inst_pc.
    cycle(0, 1, 32'h0000_0040, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 1, 32'h0000_0300, 0, 0, 1);
    chk("exc_addr", imem_addr, EXC_VEC);
    chk("exc_epc", epc, 32'h40);
`endif

    // Random traffic: stalls, redirects, variable gnt/rvalid latency, stray rvalids.
    for (int n = 0; n < 3000; n++) begin
      s   = ($urandom_range(0, 99) < 40);
      r   = ($urandom_range(0, 99) < 8);
      rpc = $urandom;
      g   = imem_req && ($urandom_range(0, 1) == 1);
      v   = m_owed ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 5);
      cycle(s, r, rpc, g, v, 1'b0);
    end

    checks++;
    assert (delivered >= 100)
    else begin
      failures++;
      $error("FAIL progress delivered=%0d required>=100", delivered);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
